// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : clock_pkg
//  Description : Shared constants for the time-counter write sequencer:
//                adjust field encoding, FSM state codes, default limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  // Adjust field selector encoding
  localparam logic [1:0] FIELD_SEC     = 2'd0;
  localparam logic [1:0] FIELD_MIN     = 2'd1;
  localparam logic [1:0] FIELD_HR      = 2'd2;
  localparam logic [1:0] FIELD_INVALID = 2'd3;

  // Write sequencer FSM state codes
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Default field moduli and settle length
  localparam int DEF_SEC_LIMIT     = 60;
  localparam int DEF_MIN_LIMIT     = 60;
  localparam int DEF_HR_LIMIT      = 24;
  localparam int DEF_SETTLE_CYCLES = 1;

  // True when the selector names a real field
  function automatic logic field_ok(input logic [1:0] f);
    return f != FIELD_INVALID;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_step.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_step
//  Description : Combinational +/-1 modulo LIMIT on one time field. Flags a
//                wrap (carry on increment, borrow on decrement). An input
//                already out of range is clamped to 0 with no wrap flag.
//                When not enabled the value passes through untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_step #(
  parameter int WIDTH = 6,
  parameter int LIMIT = 60
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             en_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] val_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LIM_M1 = WIDTH'(LIMIT - 1);

  // Step the field by one, wrapping at the modulus boundaries
  always_comb begin
    val_o  = val_i;
    wrap_o = 1'b0;
    if (en_i) begin
      if (val_i > LIM_M1) begin
        val_o = '0;
      end else if (inc_i) begin
        if (val_i == LIM_M1) begin
          val_o  = '0;
          wrap_o = 1'b1;
        end else begin
          val_o = val_i + 1'b1;
        end
      end else begin
        if (val_i == '0) begin
          val_o  = LIM_M1;
          wrap_o = 1'b1;
        end else begin
          val_o = val_i - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : core_write_sequencer
//  Description : Sole writer of the time counter core load port. Arbitrates
//                PC104 sync loads against front-panel +/-1 adjusts and runs
//                each write as CAPTURE -> STROBE -> SETTLE -> DONE while
//                counting is paused.
//  Options     : `define ADJ_CARRY_EN to let adjust wraps carry/borrow into
//                the next field up (sec -> min -> hr, hr wraps alone).
//  Revision    : 1.0 - initial release
// ============================================================================
module core_write_sequencer
  import clock_pkg::*;
#(
  parameter int SEC_LIMIT     = DEF_SEC_LIMIT,
  parameter int MIN_LIMIT     = DEF_MIN_LIMIT,
  parameter int HR_LIMIT      = DEF_HR_LIMIT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       mode_timeset,
  input  logic       sync_req,
  input  logic [4:0] sync_hr,
  input  logic [5:0] sync_min,
  input  logic [5:0] sync_sec,
  input  logic       adj_req,
  input  logic [1:0] adj_field,
  input  logic       adj_dir,
  input  logic [4:0] hr_cur,
  input  logic [5:0] min_cur,
  input  logic [5:0] sec_cur,
  output logic [4:0] hr_load,
  output logic [5:0] min_load,
  output logic [5:0] sec_load,
  output logic       modify_n,
  output logic       count_enable,
  output logic       busy,
  output logic       sync_ack,
  output logic       adj_ack,
  output logic       overrun
);

  localparam logic [4:0] HR_LIM      = 5'(HR_LIMIT);
  localparam logic [5:0] MIN_LIM     = 6'(MIN_LIMIT);
  localparam logic [5:0] SEC_LIM     = 6'(SEC_LIMIT);
  localparam logic [2:0] SETTLE_INIT = 3'(SETTLE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       serve_sync_q, serve_sync_d;
  logic       sync_pend_q, sync_pend_d;
  logic       adj_pend_q, adj_pend_d;
  logic [1:0] adj_field_q, adj_field_d;
  logic       adj_dir_q, adj_dir_d;
  logic       overrun_q, overrun_d;
  logic       sync_ack_q, sync_ack_d;
  logic       adj_ack_q, adj_ack_d;
  logic [4:0] hr_load_q, hr_load_d;
  logic [5:0] min_load_q, min_load_d;
  logic [5:0] sec_load_q, sec_load_d;

  logic       w_idle, w_capture;
  logic       w_adj_bad;
  logic       w_sync_ok, w_adj_ok, w_launch;
  logic       w_sync_rej, w_adj_rej;
  logic       w_sync_consume, w_adj_consume;
  logic       w_sec_en, w_min_en, w_hr_en;
  logic       w_sec_wrap, w_min_wrap, w_hr_wrap;
  logic [5:0] w_sec_nx, w_min_nx;
  logic [4:0] w_hr_nx;
  logic       w_unused;

  // Decision terms: mode/field gating happens only while idle
  assign w_idle         = (state_q == ST_IDLE);
  assign w_capture      = (state_q == ST_CAPTURE);
  assign w_adj_bad      = ~mode_timeset | ~field_ok(adj_field_q);
  assign w_sync_ok      = w_idle & sync_pend_q & ~mode_timeset;
  assign w_adj_ok       = w_idle & adj_pend_q & ~w_adj_bad;
  assign w_launch       = w_sync_ok | w_adj_ok;
  assign w_sync_rej     = w_idle & sync_pend_q & mode_timeset;
  assign w_adj_rej      = w_idle & adj_pend_q & w_adj_bad;
  assign w_sync_consume = w_sync_rej | (w_capture & serve_sync_q);
  assign w_adj_consume  = w_adj_rej | (w_capture & ~serve_sync_q);

  // Field step enables; with carry enabled a wrap ripples upward
  assign w_sec_en = (adj_field_q == FIELD_SEC);
`ifdef ADJ_CARRY_EN
  assign w_min_en = (adj_field_q == FIELD_MIN) | w_sec_wrap;
  assign w_hr_en  = (adj_field_q == FIELD_HR) | w_min_wrap;
`else
  assign w_min_en = (adj_field_q == FIELD_MIN);
  assign w_hr_en  = (adj_field_q == FIELD_HR);
`endif

  // Hours never carry further, and without carry no wrap flag is consumed
  assign w_unused = w_sec_wrap ^ w_min_wrap ^ w_hr_wrap;

  wrap_step #(.WIDTH(6), .LIMIT(SEC_LIMIT)) u_sec_step (
    .val_i  (sec_cur),
    .en_i   (w_sec_en),
    .inc_i  (adj_dir_q),
    .val_o  (w_sec_nx),
    .wrap_o (w_sec_wrap)
  );

  wrap_step #(.WIDTH(6), .LIMIT(MIN_LIMIT)) u_min_step (
    .val_i  (min_cur),
    .en_i   (w_min_en),
    .inc_i  (adj_dir_q),
    .val_o  (w_min_nx),
    .wrap_o (w_min_wrap)
  );

  wrap_step #(.WIDTH(5), .LIMIT(HR_LIMIT)) u_hr_step (
    .val_i  (hr_cur),
    .en_i   (w_hr_en),
    .inc_i  (adj_dir_q),
    .val_o  (w_hr_nx),
    .wrap_o (w_hr_wrap)
  );

  // Write sequence FSM, load computation and ack generation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    serve_sync_d = serve_sync_q;
    hr_load_d    = hr_load_q;
    min_load_d   = min_load_q;
    sec_load_d   = sec_load_q;
    sync_ack_d   = 1'b0;
    adj_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sync_ack_d = w_sync_rej;
        adj_ack_d  = w_adj_rej;
        if (w_launch) begin
          state_d      = ST_CAPTURE;
          serve_sync_d = w_sync_ok;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_STROBE;
        if (serve_sync_q) begin
          hr_load_d  = (sync_hr >= HR_LIM) ? '0 : sync_hr;
          min_load_d = (sync_min >= MIN_LIM) ? '0 : sync_min;
          sec_load_d = (sync_sec >= SEC_LIM) ? '0 : sync_sec;
        end else begin
          hr_load_d  = w_hr_nx;
          min_load_d = w_min_nx;
          sec_load_d = w_sec_nx;
        end
      end
      ST_STROBE: begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_INIT;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d    = ST_DONE;
          sync_ack_d = serve_sync_q;
          adj_ack_d  = ~serve_sync_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One-deep pending flags; a repeat while still pending is dropped as overrun
  always_comb begin
    sync_pend_d = sync_pend_q;
    adj_pend_d  = adj_pend_q;
    adj_field_d = adj_field_q;
    adj_dir_d   = adj_dir_q;
    overrun_d   = overrun_q;
    if (w_sync_consume) sync_pend_d = 1'b0;
    if (sync_req) begin
      if (sync_pend_q && !w_sync_consume) overrun_d = 1'b1;
      else sync_pend_d = 1'b1;
    end
    if (w_adj_consume) adj_pend_d = 1'b0;
    if (adj_req) begin
      if (adj_pend_q && !w_adj_consume) begin
        overrun_d = 1'b1;
      end else begin
        adj_pend_d  = 1'b1;
        adj_field_d = adj_field;
        adj_dir_d   = adj_dir;
      end
    end
  end

  // State registers, cleared asynchronously so the strobe releases at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      serve_sync_q <= 1'b0;
      sync_pend_q  <= 1'b0;
      adj_pend_q   <= 1'b0;
      adj_field_q  <= '0;
      adj_dir_q    <= 1'b0;
      overrun_q    <= 1'b0;
      sync_ack_q   <= 1'b0;
      adj_ack_q    <= 1'b0;
      hr_load_q    <= '0;
      min_load_q   <= '0;
      sec_load_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      serve_sync_q <= serve_sync_d;
      sync_pend_q  <= sync_pend_d;
      adj_pend_q   <= adj_pend_d;
      adj_field_q  <= adj_field_d;
      adj_dir_q    <= adj_dir_d;
      overrun_q    <= overrun_d;
      sync_ack_q   <= sync_ack_d;
      adj_ack_q    <= adj_ack_d;
      hr_load_q    <= hr_load_d;
      min_load_q   <= min_load_d;
      sec_load_q   <= sec_load_d;
    end
  end

  // Counting pauses from the launch decision until the sequencer is idle again
  assign count_enable = ~mode_timeset & w_idle & ~w_launch;
  assign modify_n     = (state_q != ST_STROBE);
  assign busy         = ~w_idle;
  assign hr_load      = hr_load_q;
  assign min_load     = min_load_q;
  assign sec_load     = sec_load_q;
  assign sync_ack     = sync_ack_q;
  assign adj_ack      = adj_ack_q;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_core_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_write_sequencer
//  Description : Self-checking bench for core_write_sequencer. Table of
//                single requests plus hand-written multi-cycle sequences;
//                expected load values queued at request time and compared
//                on every strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_write_sequencer;

`ifdef ADJ_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       mode_timeset = 1'b0;
  logic       sync_req = 1'b0;
  logic [4:0] sync_hr = '0;
  logic [5:0] sync_min = '0;
  logic [5:0] sync_sec = '0;
  logic       adj_req = 1'b0;
  logic [1:0] adj_field = '0;
  logic       adj_dir = 1'b0;
  logic [4:0] hr_cur = '0;
  logic [5:0] min_cur = '0;
  logic [5:0] sec_cur = '0;
  logic [4:0] hr_load;
  logic [5:0] min_load;
  logic [5:0] sec_load;
  logic       modify_n, count_enable, busy, sync_ack, adj_ack, overrun;

  core_write_sequencer dut (
    .clock(clock), .reset_n(reset_n), .mode_timeset(mode_timeset),
    .sync_req(sync_req), .sync_hr(sync_hr), .sync_min(sync_min), .sync_sec(sync_sec),
    .adj_req(adj_req), .adj_field(adj_field), .adj_dir(adj_dir),
    .hr_cur(hr_cur), .min_cur(min_cur), .sec_cur(sec_cur),
    .hr_load(hr_load), .min_load(min_load), .sec_load(sec_load),
    .modify_n(modify_n), .count_enable(count_enable), .busy(busy),
    .sync_ack(sync_ack), .adj_ack(adj_ack), .overrun(overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_sync;
    bit         mode;
    logic [4:0] shr;
    logic [5:0] smin, ssec;
    logic [1:0] fld;
    bit         dir;
    logic [4:0] chr;
    logic [5:0] cmin, csec;
    logic [4:0] ehr;
    logic [5:0] emin, esec;
    bit         strobe;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [16:0] sb_q [$];
  logic [16:0] sb_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clock) begin
    if (reset_n && !modify_n) begin
      strobes++;
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", sb_q.size(), 1);
      end else begin
        sb_exp = sb_q.pop_front();
        check("strobe_loads", {15'd0, hr_load, min_load, sec_load}, {15'd0, sb_exp});
      end
    end
  end

  // Drive request masks cycle by cycle and record outputs at each negedge
  task automatic trace(input int n, input logic [15:0] smask, input logic [15:0] amask,
                       input logic [31:0] fld,
                       output logic [15:0] mod_t, output logic [15:0] ce_t,
                       output logic [15:0] sack_t, output logic [15:0] aack_t,
                       output logic [15:0] busy_t, output logic [15:0] ovr_t);
    mod_t = '1; ce_t = '1; sack_t = '0; aack_t = '0; busy_t = '0; ovr_t = '0;
    for (int i = 0; i < n; i++) begin
      sync_req  = smask[i];
      adj_req   = amask[i];
      adj_field = fld[2*i +: 2];
      mod_t[i]  = modify_n;
      ce_t[i]   = count_enable;
      sack_t[i] = sync_ack;
      aack_t[i] = adj_ack;
      busy_t[i] = busy;
      ovr_t[i]  = overrun;
      @(negedge clock);
    end
    sync_req = 1'b0;
    adj_req  = 1'b0;
  endtask

  logic [15:0] t_mod, t_ce, t_sack, t_aack, t_busy, t_ovr;
  bit got;
  int s0;
  int seen;

  initial begin
    // is_sync mode shr smin ssec fld dir chr cmin csec ehr emin esec strobe
    vecs[0]  = '{1, 0, 5'd12, 6'd34, 6'd56, 2'd0, 0, 5'd1,  6'd2,  6'd3,  5'd12, 6'd34, 6'd56, 1};
    vecs[1]  = '{1, 0, 5'd30, 6'd61, 6'd60, 2'd0, 0, 5'd4,  6'd5,  6'd6,  5'd0,  6'd0,  6'd0,  1};
    vecs[2]  = '{1, 0, 5'd23, 6'd59, 6'd59, 2'd0, 0, 5'd0,  6'd0,  6'd0,  5'd23, 6'd59, 6'd59, 1};
    vecs[3]  = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd0, 1, 5'd10, 6'd10, 6'd59, 5'd10,
                 CARRY ? 6'd11 : 6'd10, 6'd0, 1};
    vecs[4]  = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd2, 0, 5'd0,  6'd5,  6'd6,  5'd23, 6'd5,  6'd6,  1};
    vecs[5]  = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd1, 0, 5'd3,  6'd0,  6'd7,
                 CARRY ? 5'd2 : 5'd3, 6'd59, 6'd7, 1};
    vecs[6]  = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd0, 0, 5'd0,  6'd0,  6'd0,
                 CARRY ? 5'd23 : 5'd0, CARRY ? 6'd59 : 6'd0, 6'd59, 1};
    vecs[7]  = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd1, 1, 5'd23, 6'd59, 6'd30,
                 CARRY ? 5'd0 : 5'd23, 6'd0, 6'd30, 1};
    vecs[8]  = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd0, 1, 5'd5,  6'd6,  6'd62, 5'd5,  6'd6,  6'd0,  1};
    vecs[9]  = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd2, 1, 5'd22, 6'd1,  6'd2,  5'd23, 6'd1,  6'd2,  1};
    vecs[10] = '{0, 1, 5'd0,  6'd0,  6'd0,  2'd3, 1, 5'd1,  6'd1,  6'd1,  5'd0,  6'd0,  6'd0,  0};
    vecs[11] = '{0, 0, 5'd0,  6'd0,  6'd0,  2'd0, 1, 5'd1,  6'd1,  6'd1,  5'd0,  6'd0,  6'd0,  0};
    vecs[12] = '{1, 1, 5'd9,  6'd9,  6'd9,  2'd0, 0, 5'd1,  6'd1,  6'd1,  5'd0,  6'd0,  6'd0,  0};

    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("reset_state",
          {9'd0, hr_load, min_load, sec_load, modify_n, count_enable, busy, sync_ack, adj_ack, overrun},
          {9'd0, 17'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    // Sequence 1: sync timing in normal mode
    mode_timeset = 1'b0;
    hr_cur = 5'd1; min_cur = 6'd2; sec_cur = 6'd3;
    sync_hr = 5'd12; sync_min = 6'd34; sync_sec = 6'd56;
    sb_q.push_back({5'd12, 6'd34, 6'd56});
    trace(16, 16'h0001, 16'h0000, 32'd0, t_mod, t_ce, t_sack, t_aack, t_busy, t_ovr);
    check("seq1_modify_n", t_mod, 16'hFFF7);
    check("seq1_count_enable", t_ce, 16'hFFC1);
    check("seq1_sync_ack", t_sack, 16'h0020);
    check("seq1_busy", t_busy, 16'h003C);

    // Table of single requests
    for (int v = 0; v < NVEC; v++) begin
      mode_timeset = vecs[v].mode;
      hr_cur = vecs[v].chr; min_cur = vecs[v].cmin; sec_cur = vecs[v].csec;
      sync_hr = vecs[v].shr; sync_min = vecs[v].smin; sync_sec = vecs[v].ssec;
      adj_field = vecs[v].fld; adj_dir = vecs[v].dir;
      repeat (2) @(negedge clock);
      s0 = strobes;
      if (vecs[v].strobe) sb_q.push_back({vecs[v].ehr, vecs[v].emin, vecs[v].esec});
      if (vecs[v].is_sync) sync_req = 1'b1;
      else adj_req = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clock);
        sync_req = 1'b0;
        adj_req  = 1'b0;
        if (vecs[v].is_sync ? sync_ack : adj_ack) got = 1'b1;
      end
      check($sformatf("vec%0d_ack", v), {31'd0, got}, 32'd1);
      repeat (2) @(negedge clock);
      check($sformatf("vec%0d_strobes", v), strobes - s0, {31'd0, vecs[v].strobe});
    end

    // Sequence 2: sync and adjust together in normal mode
    mode_timeset = 1'b0;
    hr_cur = 5'd7; min_cur = 6'd8; sec_cur = 6'd9;
    sync_hr = 5'd3; sync_min = 6'd4; sync_sec = 6'd5;
    adj_dir = 1'b1;
    s0 = strobes;
    sb_q.push_back({5'd3, 6'd4, 6'd5});
    trace(16, 16'h0001, 16'h0001, 32'd0, t_mod, t_ce, t_sack, t_aack, t_busy, t_ovr);
    check("seq2_modify_n", t_mod, 16'hFFF7);
    check("seq2_sync_ack", t_sack, 16'h0020);
    check("seq2_adj_ack", t_aack, 16'h0004);
    check("seq2_strobes", strobes - s0, 1);
    check("seq2_no_overrun", {31'd0, overrun}, 32'd0);

    // Sequence 3: back-to-back adjusts, then an overrun on the pending slot
    mode_timeset = 1'b1;
    hr_cur = 5'd0; min_cur = 6'd0; sec_cur = 6'd5;
    adj_dir = 1'b1;
    repeat (2) @(negedge clock);
    sb_q.push_back({5'd0, 6'd0, 6'd6});
    sb_q.push_back({5'd0, 6'd1, 6'd5});
    // field per cycle: i0 sec, i2 min, i4 hr
    trace(16, 16'h0000, 16'h0015, 32'h0000_0210, t_mod, t_ce, t_sack, t_aack, t_busy, t_ovr);
    check("seq3_modify_n", t_mod, 16'hFEF7);
    check("seq3_adj_ack", t_aack, 16'h0420);
    check("seq3_busy", t_busy, 16'h07BC);
    check("seq3_overrun", t_ovr, 16'hFFE0);

    // Sequence 4: reset asserted during the strobe
    mode_timeset = 1'b0;
    sync_hr = 5'd1; sync_min = 6'd2; sync_sec = 6'd3;
    sb_q.push_back({5'd1, 6'd2, 6'd3});
    trace(3, 16'h0001, 16'h0000, 32'd0, t_mod, t_ce, t_sack, t_aack, t_busy, t_ovr);
    check("seq4_strobe_low", {31'd0, modify_n}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("seq4_async_release", {30'd0, modify_n, busy}, {30'd0, 1'b1, 1'b0});
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (sync_ack || busy) seen++;
    end
    check("seq4_quiet_after_reset", seen, 0);
    check("seq4_overrun_cleared", {31'd0, overrun}, 32'd0);

    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
